// File: rtl/bin_to_digits.sv
// rtl/bin_to_digits.sv - signed binary to seven-segment digit codes via iterative double dabble
module bin_to_digits #(
    parameter int WIDTH      = 16,
    parameter int NDIG       = 6,
    parameter bit LEAD_BLANK = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    value,
    output logic                ready,
    output logic                done,
    output logic [4*NDIG-1:0]   digits,
    output logic                negative
);

    localparam int BW = 4 * (NDIG - 1);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] CODE_MINUS = 4'd10;
    localparam logic [3:0] CODE_BLANK = 4'd11;

    typedef enum logic [1:0] {IDLE, CONVERT, FORMAT} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    mag_q;
    logic [BW-1:0]       bcd_q;
    logic [BW-1:0]       bcd_adj;
    logic [CW-1:0]       cnt_q;
    logic                sign_q;
    logic [4*NDIG-1:0]   fmt_digits;
    int                  msd;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) state_d = CONVERT;
            end
            CONVERT: if (cnt_q == CW'(1)) state_d = FORMAT;
            FORMAT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // add-3 correction applied before every shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NDIG - 1; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // msd stays 0 for a zero result so position 0 still shows '0'
    always_comb begin
        msd = 0;
        for (int i = 0; i < NDIG - 1; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) msd = i;
        end
        fmt_digits = {NDIG{CODE_BLANK}};
        for (int i = 0; i < NDIG; i++) begin
            if (LEAD_BLANK) begin
                if (i < NDIG - 1 && i <= msd) fmt_digits[4*i +: 4] = bcd_q[4*i +: 4];
                else if (sign_q && i == msd + 1) fmt_digits[4*i +: 4] = CODE_MINUS;
            end else begin
                if (i < NDIG - 1) fmt_digits[4*i +: 4] = bcd_q[4*i +: 4];
                else fmt_digits[4*i +: 4] = sign_q ? CODE_MINUS : 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            done     <= 1'b0;
            negative <= 1'b0;
            digits   <= {NDIG{CODE_BLANK}};
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    sign_q <= value[WIDTH-1];
                    mag_q  <= value[WIDTH-1] ? (~value + WIDTH'(1)) : value;
                    bcd_q  <= '0;
                    cnt_q  <= CW'(WIDTH);
                end
                CONVERT: begin
                    bcd_q <= {bcd_adj[BW-2:0], mag_q[WIDTH-1]};
                    mag_q <= {mag_q[WIDTH-2:0], 1'b0};
                    cnt_q <= cnt_q - CW'(1);
                end
                FORMAT: begin
                    digits   <= fmt_digits;
                    negative <= sign_q;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_digits.sv
// tb/tb_bin_to_digits.sv - directed self-checking bench for bin_to_digits
module tb_bin_to_digits;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] value;
    logic        ready_b, done_b, neg_b;
    logic        ready_z, done_z, neg_z;
    logic [23:0] digits_b, digits_z;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bin_to_digits #(.WIDTH(16), .NDIG(6), .LEAD_BLANK(1'b1)) dut_blank (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .ready(ready_b), .done(done_b), .digits(digits_b), .negative(neg_b)
    );

    bin_to_digits #(.WIDTH(16), .NDIG(6), .LEAD_BLANK(1'b0)) dut_zero (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .ready(ready_z), .done(done_z), .digits(digits_z), .negative(neg_z)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // accept on the next edge, then wait for done; returns edges from accept to done
    task automatic convert(input int v, output int lat);
        value = 16'(v);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done_b) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_conv(input string tag, input int v, input logic [23:0] exp_b,
                            input logic exp_neg);
        int lat;
        convert(v, lat);
        check({tag, " latency"}, 32'(lat), 32'd17);
        check({tag, " digits"}, 32'(digits_b), 32'(exp_b));
        check({tag, " negative"}, 32'(neg_b), 32'(exp_neg));
        check({tag, " ready"}, 32'(ready_b), 32'd1);
        @(posedge clk); #1;
        check({tag, " done single"}, 32'(done_b), 32'd0);
    endtask

    initial begin
        int lat;
        int pulses;
        rst = 1'b1;
        start = 1'b0;
        value = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset ready", 32'(ready_b), 32'd1);
        check("reset done", 32'(done_b), 32'd0);
        check("reset negative", 32'(neg_b), 32'd0);
        check("reset digits", 32'(digits_b), 32'hBBBBBB);
        check("reset digits lb0", 32'(digits_z), 32'hBBBBBB);

        run_conv("zero", 0, 24'hBBBBB0, 1'b0);
        check("zero lb0", 32'(digits_z), 32'h000000);
        run_conv("1234", 1234, 24'hBB1234, 1'b0);
        run_conv("32767", 32767, 24'hB32767, 1'b0);
        run_conv("-5", -5, 24'hBBBBA5, 1'b1);
        check("-5 lb0", 32'(digits_z), 32'hA00005);
        check("-5 lb0 negative", 32'(neg_z), 32'd1);
        run_conv("-32768", -32768, 24'hA32768, 1'b1);
        run_conv("42", 42, 24'hBBBB42, 1'b0);
        check("42 lb0", 32'(digits_z), 32'h000042);

        // start while busy is dropped; start in the done cycle is taken
        value = 16'd100;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk); #1;
            if (done_b) pulses++;
            if (i == 4) begin
                check("busy ready", 32'(ready_b), 32'd0);
                value = 16'd999;
                start = 1'b1;
            end
            if (i == 5) start = 1'b0;
        end
        check("busy done at 17", 32'(done_b), 32'd1);
        check("busy pulses", 32'(pulses), 32'd1);
        check("busy digits", 32'(digits_b), 32'hBBB100);
        convert(999, lat);
        check("b2b latency", 32'(lat), 32'd17);
        check("b2b digits", 32'(digits_b), 32'hBBB999);

        // reset mid-conversion, with a simultaneous start
        @(posedge clk); #1;
        value = 16'd555;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b1;
        value = 16'd1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        check("abort ready", 32'(ready_b), 32'd1);
        check("abort digits", 32'(digits_b), 32'hBBBBBB);
        check("abort negative", 32'(neg_b), 32'd0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (done_b) pulses++;
            @(posedge clk); #1;
        end
        check("abort no done", 32'(pulses), 32'd0);
        run_conv("after abort", 7, 24'hBBBBB7, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin_to_digits.md
# bin_to_digits

Sequential signed-binary to display-digit converter that feeds the seven-segment decoders. It accepts a two's-complement result from the calculator datapath on a start/ready handshake. It converts the result with an iterative shift-and-add-3 (double dabble) engine, then emits one 4-bit digit code per display position: 0–9, 10 = '-', 11 = blank. The output digit codes are registered and held until the next conversion completes.

## Interface
- WIDTH, 16, bit width of the signed input value; must satisfy 10^(NDIG-1) > 2^(WIDTH-1).
- NDIG, 6, number of display positions; one position is reserved for the sign.
- LEAD_BLANK, 1, 1 = blank leading zeros with the sign hugging the number; 0 = show leading zeros with the sign in the leftmost position.

- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; accepted only when ready=1.
- value  input  WIDTH  signed two's-complement operand; sampled on the accepting edge only.
- ready  output  1  high when idle and able to accept start.
- done  output  1  one-cycle pulse; digits/negative are updated in the same cycle.
- digits  output  4*NDIG  digit codes; position i occupies bits [4i+3:4i], position 0 is rightmost.
- negative  output  1  sign of the last completed conversion.

## Operation
- States: IDLE, CONVERT, FORMAT.
- IDLE:
  - ready=1.
  - On start=1: latch mag = |value| as WIDTH-bit unsigned (-2^(WIDTH-1) → 2^(WIDTH-1), no overflow) and latch the sign.
  - Clear the BCD accumulator (4*(NDIG-1) bits), load the iteration counter with WIDTH, go to CONVERT.
- CONVERT:
  - Each cycle, every BCD nibble ≥5 gets +3, then {bcd, mag} shifts left one bit.
  - Decrement the counter; after WIDTH iterations go to FORMAT.
- FORMAT, one cycle, registers digits and negative:
  - LEAD_BLANK=1:
    - Digits above the most significant nonzero BCD digit are 11.
    - Value 0 shows code 0 in position 0 only.
    - If negative, code 10 goes in the position immediately left of the most significant nonzero digit.
  - LEAD_BLANK=0:
    - All NDIG-1 BCD digits are shown, zeros included.
    - Position NDIG-1 is 10 if negative, else 0.
  - Negative zero cannot occur; 0 is never signed.
  - Pulse done=1 for one cycle and go to IDLE.
- start while ready=0 is ignored, not queued; value changes during conversion have no effect.
- digits/negative change only in the done cycle; between conversions they hold.
- The engine is not pipelined; one conversion is in flight at most.

## Timing
- Accept edge E0 (start=1, ready=1) → ready=0 from the cycle after E0.
- WIDTH CONVERT edges, then the FORMAT edge: done=1 and new digits are visible in the cycle after edge E0+WIDTH+1 (17 cycles for WIDTH=16).
- In the done cycle the state is IDLE and ready=1, so a start in that same cycle is accepted (back-to-back throughput: one result per WIDTH+2 cycles).
- Reset values: ready=1, done=0, negative=0, every digit position = 11 (blank), state IDLE.
- rst during CONVERT/FORMAT:
  - Aborts the conversion with no done pulse.
  - The previous digits are replaced by the all-blank reset value.
  - rst has priority over a simultaneous start.

## Test plan
- Reset, then start with value=0 → done at cycle 17, digits positions 5..0 = {11,11,11,11,11,0}, negative=0.
- value=1234 → {11,11,1,2,3,4}; value=32767 → {11,3,2,7,6,7}.
- value=-5 → {11,11,11,11,10,5}, negative=1; value=-32768 → {10,3,2,7,6,8}, negative=1.
- LEAD_BLANK=0, value=-5 → {10,0,0,0,0,5}; value=42 → {0,0,0,0,4,2}.
- Start 100, then at cycle 5 assert start with value=999 → ignored; the result is 100 with a single done; a start in the done cycle with 999 is accepted and the next done comes 17 cycles later.
- Start 555, assert rst at cycle 8 → no done pulse, digits all 11, ready=1 in the cycle after the rst edge; a new conversion of 7 then completes normally as {11,11,11,11,11,7}.
